// File: rtl/end_screen_pkg.sv
`default_nettype none
// ==========================================================================
// end_screen_pkg : states, colours, glyph codes and layout for end_screen_anim
// Revision 1.0
// ==========================================================================
package end_screen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_IN  = 2'd1,
    ST_HOLD     = 2'd2,
    ST_FADE_OUT = 2'd3
  } state_t;

  localparam logic [15:0] C_BLACK = 16'h0000;
  localparam logic [15:0] C_GREEN = 16'h07E0;
  localparam logic [15:0] C_RED   = 16'hF800;
  localparam logic [15:0] C_BLUE  = 16'h001F;
  localparam logic [15:0] C_GOLD  = 16'hFD40;

  localparam logic [3:0] C_GLYPH_V     = 4'd0;
  localparam logic [3:0] C_GLYPH_I     = 4'd1;
  localparam logic [3:0] C_GLYPH_C     = 4'd2;
  localparam logic [3:0] C_GLYPH_T     = 4'd3;
  localparam logic [3:0] C_GLYPH_O     = 4'd4;
  localparam logic [3:0] C_GLYPH_R     = 4'd5;
  localparam logic [3:0] C_GLYPH_Y     = 4'd6;
  localparam logic [3:0] C_GLYPH_D     = 4'd7;
  localparam logic [3:0] C_GLYPH_E     = 4'd8;
  localparam logic [3:0] C_GLYPH_F     = 4'd9;
  localparam logic [3:0] C_GLYPH_A     = 4'd10;
  localparam logic [3:0] C_GLYPH_BLANK = 4'd15;

  localparam int C_VIC_LEN     = 7;
  localparam int C_DEF_LEN     = 6;
  localparam int C_GLYPH_W     = 8;
  localparam int C_GLYPH_PITCH = 10;
  localparam int C_TITLE_Y0    = 24;
  localparam int C_TITLE_H     = 16;
  localparam int C_STRIPE_ROWS = 16;
  localparam int C_TROPHY_W    = 16;
  localparam int C_TROPHY_H    = 10;

  // Title centred on the pitch grid; the +2 drops the trailing inter-glyph gap.
  function automatic int title_x0(input int scr_w, input int n);
    return (scr_w - C_GLYPH_PITCH * n + 2) / 2;
  endfunction

  function automatic logic [3:0] title_glyph(input logic victory, input logic [2:0] idx);
    logic [3:0] g;
    g = C_GLYPH_BLANK;
    if (victory) begin
      case (idx)
        3'd0: g = C_GLYPH_V;
        3'd1: g = C_GLYPH_I;
        3'd2: g = C_GLYPH_C;
        3'd3: g = C_GLYPH_T;
        3'd4: g = C_GLYPH_O;
        3'd5: g = C_GLYPH_R;
        3'd6: g = C_GLYPH_Y;
        default: g = C_GLYPH_BLANK;
      endcase
    end else begin
      case (idx)
        3'd0: g = C_GLYPH_D;
        3'd1: g = C_GLYPH_E;
        3'd2: g = C_GLYPH_F;
        3'd3: g = C_GLYPH_E;
        3'd4: g = C_GLYPH_A;
        3'd5: g = C_GLYPH_T;
        default: g = C_GLYPH_BLANK;
      endcase
    end
    return g;
  endfunction

  // Trophy bitmap, MSB is the leftmost column: cup with handles, stem, base.
  function automatic logic [15:0] trophy_row(input logic [3:0] t);
    logic [15:0] m;
    case (t)
      4'd0:    m = 16'b0011111111111100;
      4'd1:    m = 16'b1111111111111111;
      4'd2:    m = 16'b1011111111111101;
      4'd3:    m = 16'b1101111111111011;
      4'd4:    m = 16'b0001111111111000;
      4'd5:    m = 16'b0000111111110000;
      4'd6:    m = 16'b0000001111000000;
      4'd7:    m = 16'b0000001111000000;
      4'd8:    m = 16'b0000111111110000;
      4'd9:    m = 16'b0011111111111100;
      default: m = 16'b0000000000000000;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/end_glyph_rom.sv
`default_nettype none
// ==========================================================================
// end_glyph_rom : 8x16 block-letter glyphs for the end-screen titles
// Revision 1.0
// ==========================================================================
module end_glyph_rom
  import end_screen_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic [3:0] row_i,
  input  logic [2:0] col_i,
  output logic       pix_o
);

  logic w_left, w_right, w_centre, w_inner, w_top, w_bot, w_mid;

  // Glyphs are built from 2-px strokes rather than stored bitmaps.
  assign w_left   = (col_i <= 3'd1);
  assign w_right  = (col_i >= 3'd6);
  assign w_centre = (col_i == 3'd3) || (col_i == 3'd4);
  assign w_inner  = (col_i >= 3'd1) && (col_i <= 3'd6);
  assign w_top    = (row_i <= 4'd1);
  assign w_bot    = (row_i >= 4'd14);
  assign w_mid    = (row_i == 4'd7) || (row_i == 4'd8);

  always_comb begin
    pix_o = 1'b0;
    case (code_i)
      C_GLYPH_V: begin
        if (row_i <= 4'd9)       pix_o = w_left | w_right;
        else if (row_i <= 4'd11) pix_o = (col_i == 3'd1) || (col_i == 3'd2) ||
                                         (col_i == 3'd5) || (col_i == 3'd6);
        else if (row_i <= 4'd13) pix_o = (col_i >= 3'd2) && (col_i <= 3'd5);
        else                     pix_o = w_centre;
      end
      C_GLYPH_I: pix_o = (w_top | w_bot) ? w_inner : w_centre;
      C_GLYPH_C: pix_o = (w_top | w_bot) ? (col_i >= 3'd1) : w_left;
      C_GLYPH_T: pix_o = w_top | w_centre;
      C_GLYPH_O: pix_o = (w_top | w_bot) ? w_inner : (w_left | w_right);
      C_GLYPH_R: begin
        if (w_top | w_mid)       pix_o = (col_i <= 3'd6);
        else if (row_i <= 4'd6)  pix_o = w_left | w_right;
        else if (row_i <= 4'd11) pix_o = w_left | (col_i == 3'd5) | (col_i == 3'd6);
        else                     pix_o = w_left | w_right;
      end
      C_GLYPH_Y: begin
        if (row_i <= 4'd5)      pix_o = w_left | w_right;
        else if (row_i <= 4'd7) pix_o = w_inner;
        else                    pix_o = w_centre;
      end
      C_GLYPH_D: pix_o = (w_top | w_bot) ? (col_i <= 3'd5) : (w_left | w_right);
      C_GLYPH_E: pix_o = w_top | w_mid | w_bot | w_left;
      C_GLYPH_F: pix_o = w_top | w_mid | w_left;
      C_GLYPH_A: pix_o = w_top ? w_inner : (w_mid | w_left | w_right);
      default:   pix_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/end_screen_anim.sv
`default_nettype none
// ==========================================================================
// end_screen_anim : animated VICTORY/DEFEAT screen with fade, blink, scroll
// Revision 1.0
// ==========================================================================
module end_screen_anim
  import end_screen_pkg::*;
#(
  parameter int          SCR_W       = 96,
  parameter int          SCR_H       = 64,
  parameter int          TICK_DIV    = 6_250_000,
  parameter int          FADE_STEPS  = 8,
  parameter int          BLINK_TICKS = 8,
  parameter int          HOLD_TICKS  = 32,
  parameter logic [15:0] TEXT_COLOR  = 16'hFFFF
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        result,
  input  logic        ack,
  input  logic [6:0]  x,
  input  logic [5:0]  y,
  output logic [15:0] pixel_data,
  output logic        active,
  output logic        done
);

  localparam int C_FS_W   = $clog2(FADE_STEPS);
  localparam int C_LVL_W  = C_FS_W + 1;
  localparam int C_TDIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int C_HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam int C_BLNK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int C_PR_W   = 5 + C_FS_W + 1;
  localparam int C_PG_W   = 6 + C_FS_W + 1;

  localparam logic [C_LVL_W-1:0]  C_LVL_TOP   = C_LVL_W'(FADE_STEPS - 1);
  localparam logic [C_LVL_W-1:0]  C_LVL_ONE   = C_LVL_W'(1);
  localparam logic [C_TDIV_W-1:0] C_TDIV_LAST = C_TDIV_W'(TICK_DIV - 1);
  localparam logic [C_HOLD_W-1:0] C_HOLD_MAX  = C_HOLD_W'(HOLD_TICKS);
  localparam logic [C_BLNK_W-1:0] C_BLNK_LAST = C_BLNK_W'(BLINK_TICKS - 1);
  localparam logic [7:0] C_VIC_X0    = 8'(title_x0(SCR_W, C_VIC_LEN));
  localparam logic [7:0] C_DEF_X0    = 8'(title_x0(SCR_W, C_DEF_LEN));
  localparam logic [7:0] C_TROPHY_X0 = 8'(SCR_W / 2 - C_TROPHY_W / 2);
  localparam logic [6:0] C_TROPHY_Y0 = 7'(SCR_H - C_TROPHY_H - 4);

  state_t                state_q;
  logic                  result_q;
  logic [C_LVL_W-1:0]    level_q;
  logic [C_TDIV_W-1:0]   tcnt_q;
  logic [C_HOLD_W-1:0]   hold_q;
  logic [C_BLNK_W-1:0]   blink_cnt_q;
  logic                  blink_q;
  logic [3:0]            scroll_q;
  logic                  active_q;
  logic                  done_q;
  logic [15:0]           pixel_q;
  logic [15:0]           pixel_d;

  logic w_tick;
  assign w_tick = (state_q != ST_IDLE) && (tcnt_q == C_TDIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      result_q    <= 1'b0;
      level_q     <= '0;
      tcnt_q      <= '0;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      scroll_q    <= '0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != ST_IDLE)
        tcnt_q <= w_tick ? '0 : tcnt_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            result_q    <= result;
            level_q     <= '0;
            tcnt_q      <= '0;
            hold_q      <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            scroll_q    <= '0;
            active_q    <= 1'b1;
            state_q     <= ST_FADE_IN;
          end
        end
        ST_FADE_IN: begin
          if (w_tick) begin
            level_q <= level_q + 1'b1;
            if (level_q == C_LVL_TOP)
              state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Restarting the tick counter makes the fade-out a fixed length.
          if (ack && (hold_q == C_HOLD_MAX)) begin
            tcnt_q  <= '0;
            state_q <= ST_FADE_OUT;
          end else if (w_tick) begin
            scroll_q <= scroll_q + 4'd1;
            if (hold_q != C_HOLD_MAX)
              hold_q <= hold_q + 1'b1;
            if (blink_cnt_q == C_BLNK_LAST) begin
              blink_cnt_q <= '0;
              blink_q     <= ~blink_q;
            end else begin
              blink_cnt_q <= blink_cnt_q + 1'b1;
            end
          end
        end
        ST_FADE_OUT: begin
          if (w_tick) begin
            level_q <= level_q - 1'b1;
            if (level_q == C_LVL_ONE) begin
              state_q  <= ST_IDLE;
              active_q <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [7:0]  w_x8;
  logic [6:0]  w_y7;
  logic [7:0]  w_tx0;
  logic [2:0]  w_tlen;
  logic        w_title_hit;
  logic [2:0]  w_gidx;
  logic [2:0]  w_gcol;
  logic [3:0]  w_grow;
  logic [3:0]  w_gcode;
  logic        w_gpix;
  logic        w_in_title;
  logic        w_show_title;
  logic [3:0]  w_srow;
  logic        w_in_trophy;
  logic [15:0] w_trow;
  logic [3:0]  w_tdx;
  logic        w_tbit;
  logic [15:0] w_scene;

  assign w_x8   = {1'b0, x};
  assign w_y7   = {1'b0, y};
  assign w_tx0  = result_q ? C_VIC_X0 : C_DEF_X0;
  assign w_tlen = result_q ? 3'(C_VIC_LEN) : 3'(C_DEF_LEN);

  always_comb begin
    w_title_hit = 1'b0;
    w_gidx      = '0;
    w_gcol      = '0;
    for (int i = 0; i < C_VIC_LEN; i++) begin
      if ((3'(i) < w_tlen) &&
          (w_x8 >= w_tx0 + 8'(C_GLYPH_PITCH * i)) &&
          (w_x8 <  w_tx0 + 8'(C_GLYPH_PITCH * i + C_GLYPH_W))) begin
        w_title_hit = 1'b1;
        w_gidx      = 3'(i);
        w_gcol      = 3'(w_x8 - w_tx0 - 8'(C_GLYPH_PITCH * i));
      end
    end
  end

  assign w_in_title   = (w_y7 >= 7'(C_TITLE_Y0)) && (w_y7 < 7'(C_TITLE_Y0 + C_TITLE_H));
  assign w_grow       = 4'(w_y7 - 7'(C_TITLE_Y0));
  assign w_gcode      = title_glyph(result_q, w_gidx);
  assign w_show_title = (state_q != ST_HOLD) || !blink_q;

  end_glyph_rom u_glyph_rom (
    .code_i (w_gcode),
    .row_i  (w_grow),
    .col_i  (w_gcol),
    .pix_o  (w_gpix)
  );

  assign w_srow      = y[3:0] + scroll_q;
  assign w_in_trophy = (w_y7 >= C_TROPHY_Y0) && (w_y7 < C_TROPHY_Y0 + 7'(C_TROPHY_H)) &&
                       (w_x8 >= C_TROPHY_X0) && (w_x8 < C_TROPHY_X0 + 8'(C_TROPHY_W));
  assign w_trow      = trophy_row(4'(w_y7 - C_TROPHY_Y0));
  assign w_tdx       = 4'(w_x8 - C_TROPHY_X0);
  assign w_tbit      = w_trow[4'd15 - w_tdx];

  always_comb begin
    w_scene = C_BLACK;
    if (w_y7 < 7'(C_STRIPE_ROWS)) begin
      if (result_q) begin
        if (w_srow == 4'd3)                          w_scene = C_GREEN;
        else if ((w_srow == 4'd8) || (w_srow == 4'd9)) w_scene = C_RED;
        else if (w_srow >= 4'd13)                    w_scene = C_BLUE;
      end else if ((w_srow == 4'd3) || (w_srow == 4'd8) || (w_srow == 4'd9) ||
                   (w_srow >= 4'd13)) begin
        w_scene = C_RED;
      end
    end
    if (result_q && w_in_trophy && w_tbit)
      w_scene = C_GOLD;
    if (w_in_title && w_title_hit && w_gpix && w_show_title)
      w_scene = TEXT_COLOR;
  end

  // Products carry one extra bit so level == FADE_STEPS passes colours through exactly.
  logic [C_PR_W-1:0] w_prod_r;
  logic [C_PG_W-1:0] w_prod_g;
  logic [C_PR_W-1:0] w_prod_b;

  assign w_prod_r = C_PR_W'(w_scene[15:11]) * C_PR_W'(level_q);
  assign w_prod_g = C_PG_W'(w_scene[10:5])  * C_PG_W'(level_q);
  assign w_prod_b = C_PR_W'(w_scene[4:0])   * C_PR_W'(level_q);

  assign pixel_d = (state_q == ST_IDLE) ? 16'h0000 :
                   {5'(w_prod_r >> C_FS_W), 6'(w_prod_g >> C_FS_W), 5'(w_prod_b >> C_FS_W)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pixel_q <= '0;
    else       pixel_q <= pixel_d;
  end

  assign pixel_data = pixel_q;
  assign active     = active_q;
  assign done       = done_q;

endmodule
`default_nettype wire
